vx_ifetch_sched: RTL and testbench

VX_IFETCH_SCHED -- requirements
Module: VX_ifetch_sched

---
 rtl/vx_ifetch_sched.sv | 188 ++++++++++++++++++
 tb/tb_vx_ifetch_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ifetch_sched.sv
// Round-robin instruction-fetch scheduler: tracks per-warp PC/mask/stall state and issues one registered fetch request per cycle.
// Optional feature: define VX_IFETCH_SCHED_UUID_EN to tag each issued request with a wrapping sequence number.
module vx_ifetch_sched #(
   parameter int          NUM_WARPS    = 4,
   parameter int          NUM_THREADS  = 4,
   parameter int          UUID_BITS    = 16,
   parameter logic [31:0] STARTUP_ADDR = 32'h80000000,
   localparam int         NW_BITS      = $clog2(NUM_WARPS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   spawn_valid,
   input  logic [NW_BITS-1:0]     spawn_wid,
   input  logic [31:0]            spawn_pc,
   input  logic [NUM_THREADS-1:0] spawn_tmask,
   input  logic                   tmc_valid,
   input  logic [NW_BITS-1:0]     tmc_wid,
   input  logic [NUM_THREADS-1:0] tmc_tmask,
   input  logic                   branch_valid,
   input  logic [NW_BITS-1:0]     branch_wid,
   input  logic [31:0]            branch_pc,
   input  logic                   unstall_valid,
   input  logic [NW_BITS-1:0]     unstall_wid,
   output logic                   ifetch_req_valid,
   output logic [UUID_BITS-1:0]   ifetch_req_uuid,
   output logic [NUM_THREADS-1:0] ifetch_req_tmask,
   output logic [NW_BITS-1:0]     ifetch_req_wid,
   output logic [31:0]            ifetch_req_PC,
   input  logic                   ifetch_req_ready,
   output logic                   busy
);

   logic [NUM_WARPS-1:0]   active_q, active_d;
   logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
   logic [31:0]            pc_q [NUM_WARPS];
   logic [31:0]            pc_d [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
   logic [NUM_WARPS-1:0]   eligible;

   logic [NW_BITS-1:0]     rr_ptr_q, rr_ptr_d;
   logic                   req_valid_q, req_valid_d;
   logic [NW_BITS-1:0]     req_wid_q, req_wid_d;
   logic [31:0]            req_pc_q, req_pc_d;
   logic [NUM_THREADS-1:0] req_tmask_q, req_tmask_d;

   logic                   load_slot;
   logic                   sel_found;
   logic [NW_BITS-1:0]     sel_wid;
   logic                   issue;

   assign load_slot = ~req_valid_q | ifetch_req_ready;
   assign issue     = load_slot & sel_found;

   always_comb begin
      eligible  = '0;
      sel_found = 1'b0;
      sel_wid   = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         eligible[w] = active_q[w] & ~stalled_q[w] & (|tmask_q[w]);
      end
      // NUM_WARPS is a power of two, so the NW_BITS-wide sum wraps the search for free
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (!sel_found && eligible[rr_ptr_q + NW_BITS'(i)]) begin
            sel_found = 1'b1;
            sel_wid   = rr_ptr_q + NW_BITS'(i);
         end
      end
   end

   // Later assignments win, so the order below encodes spawn > tmc > branch > unstall > issue.
   always_comb begin
      active_d  = active_q;
      stalled_d = stalled_q;
      pc_d      = pc_q;
      tmask_d   = tmask_q;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (issue && sel_wid == NW_BITS'(w)) begin
            stalled_d[w] = 1'b1;
            pc_d[w]      = pc_q[w] + 32'd4;
         end
         if (unstall_valid && unstall_wid == NW_BITS'(w)) begin
            stalled_d[w] = 1'b0;
         end
         if (branch_valid && branch_wid == NW_BITS'(w)) begin
            stalled_d[w] = 1'b0;
            pc_d[w]      = branch_pc;
         end
         if (tmc_valid && tmc_wid == NW_BITS'(w)) begin
            stalled_d[w] = 1'b0;
            tmask_d[w]   = tmc_tmask;
            if (tmc_tmask == '0) begin
               active_d[w] = 1'b0;
            end
         end
         if (spawn_valid && spawn_wid == NW_BITS'(w)) begin
            active_d[w]  = 1'b1;
            stalled_d[w] = 1'b0;
            pc_d[w]      = spawn_pc;
            tmask_d[w]   = spawn_tmask;
         end
      end
   end

   always_comb begin
      req_valid_d = req_valid_q;
      req_wid_d   = req_wid_q;
      req_pc_d    = req_pc_q;
      req_tmask_d = req_tmask_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_slot) begin
         req_valid_d = sel_found;
         if (sel_found) begin
            req_wid_d   = sel_wid;
            req_pc_d    = pc_q[sel_wid];
            req_tmask_d = tmask_q[sel_wid];
            rr_ptr_d    = sel_wid + NW_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q  <= NUM_WARPS'(1);
         stalled_q <= '0;
         for (int w = 0; w < NUM_WARPS; w++) begin
            pc_q[w]    <= (w == 0) ? STARTUP_ADDR : 32'd0;
            tmask_q[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
         end
      end else begin
         active_q  <= active_d;
         stalled_q <= stalled_d;
         pc_q      <= pc_d;
         tmask_q   <= tmask_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         req_valid_q <= 1'b0;
         req_wid_q   <= '0;
         req_pc_q    <= '0;
         req_tmask_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         req_valid_q <= req_valid_d;
         req_wid_q   <= req_wid_d;
         req_pc_q    <= req_pc_d;
         req_tmask_q <= req_tmask_d;
      end
   end

`ifdef VX_IFETCH_SCHED_UUID_EN
   logic [UUID_BITS-1:0] uuid_cnt_q, uuid_cnt_d;
   logic [UUID_BITS-1:0] req_uuid_q, req_uuid_d;

   always_comb begin
      uuid_cnt_d = uuid_cnt_q;
      req_uuid_d = req_uuid_q;
      if (issue) begin
         req_uuid_d = uuid_cnt_q;
         uuid_cnt_d = uuid_cnt_q + UUID_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uuid_cnt_q <= '0;
         req_uuid_q <= '0;
      end else begin
         uuid_cnt_q <= uuid_cnt_d;
         req_uuid_q <= req_uuid_d;
      end
   end

   assign ifetch_req_uuid = req_uuid_q;
`else
   assign ifetch_req_uuid = '0;
`endif

   assign ifetch_req_valid = req_valid_q;
   assign ifetch_req_wid   = req_wid_q;
   assign ifetch_req_PC    = req_pc_q;
   assign ifetch_req_tmask = req_tmask_q;
   assign busy             = |active_q;

endmodule

// File: tb/tb_vx_ifetch_sched.sv
// Scoreboard bench for vx_ifetch_sched: directed control sequences push expected fetches; a negedge monitor pops them on each handshake.
module tb_vx_ifetch_sched;
   localparam int NUM_WARPS   = 4;
   localparam int NUM_THREADS = 4;
   localparam int UUID_BITS   = 4;
   localparam int NW_BITS     = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   spawn_valid, tmc_valid, branch_valid, unstall_valid;
   logic [NW_BITS-1:0]     spawn_wid, tmc_wid, branch_wid, unstall_wid;
   logic [31:0]            spawn_pc, branch_pc;
   logic [NUM_THREADS-1:0] spawn_tmask, tmc_tmask;
   logic                   ifetch_req_valid, ifetch_req_ready, busy;
   logic [UUID_BITS-1:0]   ifetch_req_uuid;
   logic [NUM_THREADS-1:0] ifetch_req_tmask;
   logic [NW_BITS-1:0]     ifetch_req_wid;
   logic [31:0]            ifetch_req_PC;

   typedef struct packed {
      logic [NW_BITS-1:0]     wid;
      logic [31:0]            pc;
      logic [NUM_THREADS-1:0] tmask;
      logic [UUID_BITS-1:0]   uuid;
   } req_t;

   req_t exp_q[$];
   req_t mon_exp;
   int   total = 0;
   int   bad = 0;
   int   uuid_seq = 0;

   vx_ifetch_sched #(
      .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS), .UUID_BITS(UUID_BITS), .STARTUP_ADDR(32'h80000000)
   ) dut (
      .clk(clk), .reset(reset),
      .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
      .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
      .branch_valid(branch_valid), .branch_wid(branch_wid), .branch_pc(branch_pc),
      .unstall_valid(unstall_valid), .unstall_wid(unstall_wid),
      .ifetch_req_valid(ifetch_req_valid), .ifetch_req_uuid(ifetch_req_uuid),
      .ifetch_req_tmask(ifetch_req_tmask), .ifetch_req_wid(ifetch_req_wid),
      .ifetch_req_PC(ifetch_req_PC), .ifetch_req_ready(ifetch_req_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   // The uuid is consumed at issue time, so it is assigned when the expectation is queued.
   task automatic push_expect(input logic [NW_BITS-1:0] wid, input logic [31:0] pc, input logic [NUM_THREADS-1:0] tmask);
      req_t r;
      r.wid   = wid;
      r.pc    = pc;
      r.tmask = tmask;
`ifdef VX_IFETCH_SCHED_UUID_EN
      r.uuid  = UUID_BITS'(uuid_seq);
`else
      r.uuid  = '0;
`endif
      uuid_seq++;
      exp_q.push_back(r);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset && ifetch_req_valid && ifetch_req_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_req: got wid=%0d pc=%0h, wanted no request", ifetch_req_wid, ifetch_req_PC);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("req_wid", 64'(ifetch_req_wid), 64'(mon_exp.wid));
            check_output("req_pc", 64'(ifetch_req_PC), 64'(mon_exp.pc));
            check_output("req_tmask", 64'(ifetch_req_tmask), 64'(mon_exp.tmask));
            check_output("req_uuid", 64'(ifetch_req_uuid), 64'(mon_exp.uuid));
         end
      end
   end

   initial begin
      reset = 1'b1;
      ifetch_req_ready = 1'b1;
      spawn_valid = 1'b0; spawn_wid = '0; spawn_pc = '0; spawn_tmask = '0;
      tmc_valid = 1'b0; tmc_wid = '0; tmc_tmask = '0;
      branch_valid = 1'b0; branch_wid = '0; branch_pc = '0;
      unstall_valid = 1'b0; unstall_wid = '0;
      tick(); tick();
      check_output("rst_valid", 64'(ifetch_req_valid), 64'd0);
      check_output("rst_pc", 64'(ifetch_req_PC), 64'd0);
      check_output("rst_tmask", 64'(ifetch_req_tmask), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd1);

      // Warp 0 boots at the startup address with one thread, then stalls until released.
      reset = 1'b0;
      push_expect(0, 32'h80000000, 4'h1);
      tick();
      check_output("boot_valid", 64'(ifetch_req_valid), 64'd1);
      tick();
      check_output("stalled_idle", 64'(ifetch_req_valid), 64'd0);
      unstall_valid = 1'b1; unstall_wid = 0;
      tick();
      unstall_valid = 1'b0;
      check_output("unstall_latency", 64'(ifetch_req_valid), 64'd0);
      push_expect(0, 32'h80000004, 4'h1);
      tick();

      // Spawn warps 1..3 while the warp-0 request is held.
      ifetch_req_ready = 1'b0;
      spawn_valid = 1'b1; spawn_tmask = 4'hF;
      spawn_wid = 1; spawn_pc = 32'h1000; tick();
      spawn_wid = 2; spawn_pc = 32'h2000; tick();
      spawn_wid = 3; spawn_pc = 32'h3000; tick();
      spawn_valid = 1'b0;
      check_output("held_wid", 64'(ifetch_req_wid), 64'd0);
      check_output("held_pc", 64'(ifetch_req_PC), 64'h80000004);

      ifetch_req_ready = 1'b1;
      unstall_valid = 1'b1; unstall_wid = 0;
      push_expect(1, 32'h1000, 4'hF);
      push_expect(2, 32'h2000, 4'hF);
      tick();
      unstall_wid = 1;
      tick();
      ifetch_req_ready = 1'b0; unstall_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_output("stall_valid", 64'(ifetch_req_valid), 64'd1);
         check_output("stall_wid", 64'(ifetch_req_wid), 64'd2);
         check_output("stall_pc", 64'(ifetch_req_PC), 64'h2000);
         check_output("stall_tmask", 64'(ifetch_req_tmask), 64'hF);
      end

      ifetch_req_ready = 1'b1;
      unstall_valid = 1'b1; unstall_wid = 2;
      push_expect(3, 32'h3000, 4'hF);
      push_expect(0, 32'h80000008, 4'h1);
      push_expect(1, 32'h1004, 4'hF);
      push_expect(2, 32'h2004, 4'hF);
      push_expect(3, 32'h3004, 4'hF);
      push_expect(0, 32'h8000000C, 4'h1);
      push_expect(1, 32'h1008, 4'hF);
      push_expect(2, 32'h2008, 4'hF);
      tick();
      check_output("after_hold_wid", 64'(ifetch_req_wid), 64'd3);
      unstall_wid = 3; tick();
      unstall_wid = 0; tick();
      unstall_wid = 1; tick();
      unstall_wid = 2; tick();
      unstall_valid = 1'b0;
      repeat (5) tick();
      check_output("rr_drain_valid", 64'(ifetch_req_valid), 64'd0);
      check_output("rr_drain_queue", 64'(exp_q.size()), 64'd0);

      // Controls with valid low must be ignored.
      spawn_wid = 3; spawn_pc = 32'hDEAD0000; spawn_tmask = 4'hF;
      branch_wid = 3; branch_pc = 32'hBAD0;
      unstall_wid = 3;
      tick();
      spawn_wid = 0; spawn_pc = 0; spawn_tmask = 0; branch_wid = 0; branch_pc = 0;
      tick();
      check_output("ignored_valid", 64'(ifetch_req_valid), 64'd0);

      branch_valid = 1'b1; branch_wid = 1; branch_pc = 32'h500;
      unstall_valid = 1'b1; unstall_wid = 1;
      push_expect(1, 32'h500, 4'hF);
      tick();
      branch_valid = 1'b0; unstall_valid = 1'b0;
      tick();
      tmc_valid = 1'b1; tmc_wid = 1; tmc_tmask = 4'h0;
      tick();
      tmc_valid = 1'b0;
      unstall_valid = 1'b1; unstall_wid = 1;
      tick();
      unstall_valid = 1'b0;
      tick();
      check_output("tmc0_idle_a", 64'(ifetch_req_valid), 64'd0);
      tick();
      check_output("tmc0_idle_b", 64'(ifetch_req_valid), 64'd0);

      spawn_valid = 1'b1; spawn_wid = 2; spawn_pc = 32'h4000; spawn_tmask = 4'h3;
      tmc_valid = 1'b1; tmc_wid = 2; tmc_tmask = 4'h0;
      push_expect(2, 32'h4000, 4'h3);
      tick();
      spawn_valid = 1'b0; tmc_valid = 1'b0;
      tick();
      tmc_valid = 1'b1; tmc_tmask = 4'h0;
      tmc_wid = 0; tick();
      tmc_wid = 2; tick();
      check_output("busy_one_left", 64'(busy), 64'd1);
      tmc_wid = 3; tick();
      tmc_valid = 1'b0;
      check_output("busy_all_clear", 64'(busy), 64'd0);
      check_output("ctrl_queue", 64'(exp_q.size()), 64'd0);

      // Reset while a request is held must drop it immediately.
      ifetch_req_ready = 1'b0;
      spawn_valid = 1'b1; spawn_wid = 1; spawn_pc = 32'h6000; spawn_tmask = 4'hF;
      tick();
      spawn_valid = 1'b0;
      tick();
      uuid_seq++;
      check_output("pre_rst_valid", 64'(ifetch_req_valid), 64'd1);
      check_output("pre_rst_pc", 64'(ifetch_req_PC), 64'h6000);
      tick();
      #2 reset = 1'b1;
      #1;
      check_output("async_rst_valid", 64'(ifetch_req_valid), 64'd0);
      check_output("async_rst_wid", 64'(ifetch_req_wid), 64'd0);
      check_output("async_rst_uuid", 64'(ifetch_req_uuid), 64'd0);
      check_output("async_rst_busy", 64'(busy), 64'd1);
      uuid_seq = 0;
      ifetch_req_ready = 1'b1;
      tick();
      reset = 1'b0;
      push_expect(0, 32'h80000000, 4'h1);
      tick();
      check_output("reboot_valid", 64'(ifetch_req_valid), 64'd1);
      check_output("reboot_pc", 64'(ifetch_req_PC), 64'h80000000);
      for (int i = 1; i <= 18; i++) begin
         push_expect(0, 32'h80000000 + 32'(4 * i), 4'h1);
         unstall_valid = 1'b1; unstall_wid = 0;
         tick();
         unstall_valid = 1'b0;
         tick();
      end
      tick(); tick();
      check_output("final_queue", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
